counter_b4_monitor: RTL

//  Downstream consumer of the 4-bit up/down/+3/load counter. Observes the counter's stimuli (enable, mode, D)
//  and its outputs (Q, load), predicts the next Q each cycle, and flags mismatches.

---
 rtl/counter_b4_pkg.sv | 18 +
 rtl/counter_b4_predict.sv | 36 +++
 rtl/counter_b4_monitor.sv | 120 ++++++++++++
 3 files changed

// File: rtl/counter_b4_pkg.sv
// rtl/counter_b4_pkg.sv - shared constants and types for the 4-bit counter monitor
package counter_b4_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] MODE_UP3 = 2'b00;
    localparam logic [1:0] MODE_DN1 = 2'b01;
    localparam logic [1:0] MODE_UP1 = 2'b10;
    localparam logic [1:0] MODE_LD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_TRACK = 2'b10,
        ST_FAIL  = 2'b11
    } state_t;

endpackage

// File: rtl/counter_b4_predict.sv
// rtl/counter_b4_predict.sv - combinational next-Q and wrap prediction for one counter step
module counter_b4_predict
    import counter_b4_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] q,
    input  logic [CNT_W-1:0] d,
    output logic [CNT_W-1:0] exp_q,
    output logic             wrap
);

    // One counter step: modulo-16 arithmetic, wrap flagged when the step crosses 15/0
    always_comb begin
        exp_q = q;
        wrap  = 1'b0;
        case (mode)
            MODE_UP3: begin
                exp_q = q + CNT_W'(3);
                wrap  = (q >= CNT_W'(13));
            end
            MODE_DN1: begin
                exp_q = q - CNT_W'(1);
                wrap  = (q == '0);
            end
            MODE_UP1: begin
                exp_q = q + CNT_W'(1);
                wrap  = (q == '1);
            end
            default: begin
                exp_q = d;
                wrap  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/counter_b4_monitor.sv
// rtl/counter_b4_monitor.sv - tracks the 4-bit counter, predicts Q each cycle and flags mismatches
module counter_b4_monitor
    import counter_b4_pkg::*;
#(
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8,
    parameter bit CHECK_LOAD = 1'b1
) (
    input  logic              b4_clk,
    input  logic              b4_reset_n,
    input  logic              b4_enable,
    input  logic [1:0]        b4_mode,
    input  logic [CNT_W-1:0]  b4_D,
    input  logic [CNT_W-1:0]  b4_Q,
    input  logic              b4_load,
    input  logic              mon_clear,
    output logic [1:0]        mon_state,
    output logic              mon_match,
    output logic              mon_err,
    output logic [ERR_W-1:0]  mon_err_cnt,
    output logic [WRAP_W-1:0] mon_wrap_cnt,
    output logic [CNT_W-1:0]  mon_exp_q
);

    logic             en_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] d_r;
    logic [CNT_W-1:0] q_r;
    state_t           state;

    logic [CNT_W-1:0] pred_q;
    logic             pred_wrap;
    logic             compare;
    logic             q_ok;
    logic             load_ok;
    logic             ok;

    counter_b4_predict u_predict (
        .mode  (mode_r),
        .q     (q_r),
        .d     (d_r),
        .exp_q (pred_q),
        .wrap  (pred_wrap)
    );

    // A compare is owed only for an enabled edge seen while already tracking
    assign compare   = en_r && ((state == ST_TRACK) || (state == ST_FAIL));
    assign q_ok      = (b4_Q == pred_q);
    assign load_ok   = !CHECK_LOAD || (b4_load == (mode_r == MODE_LD));
    assign ok        = q_ok && load_ok;
    assign mon_state = state;

    // Capture the counter's stimuli and pre-edge Q every cycle as the baseline for the next prediction
    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            en_r   <= 1'b0;
            mode_r <= MODE_UP3;
            d_r    <= '0;
            q_r    <= '0;
        end else begin
            en_r   <= b4_enable;
            mode_r <= b4_mode;
            d_r    <= b4_D;
            q_r    <= b4_Q;
        end
    end

    // Monitor FSM with compare result, sticky error and event counters; clear wins over a mismatch
    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            state        <= ST_IDLE;
            mon_match    <= 1'b0;
            mon_err      <= 1'b0;
            mon_err_cnt  <= '0;
            mon_wrap_cnt <= '0;
            mon_exp_q    <= '0;
        end else if (mon_clear) begin
            state        <= ST_IDLE;
            mon_match    <= 1'b0;
            mon_err      <= 1'b0;
            mon_err_cnt  <= '0;
            mon_wrap_cnt <= '0;
        end else begin
            mon_match <= compare && ok;
            if (compare) begin
                mon_exp_q <= pred_q;
                if (pred_wrap) begin
                    mon_wrap_cnt <= mon_wrap_cnt + WRAP_W'(1);
                end
                if (!ok) begin
                    mon_err <= 1'b1;
                    if (mon_err_cnt != '1) begin
                        mon_err_cnt <= mon_err_cnt + ERR_W'(1);
                    end
                end
            end
            case (state)
                ST_IDLE: begin
                    if (b4_enable) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    state <= b4_enable ? ST_TRACK : ST_IDLE;
                end
                ST_TRACK: begin
                    if (compare && !ok) begin
                        state <= ST_FAIL;
                    end else if (!b4_enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_FAIL;
                end
            endcase
        end
    end

endmodule
